// File: rtl/axi4_slave_mem_pkg.sv
// Shared response/burst codes, channel state enums and burst-legality helpers for axi4_slave_mem.
// AXI4_SLAVE_MEM_WRAP_EN selects whether WRAP bursts are served or rejected with SLVERR.
package axi4_slave_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

`ifdef AXI4_SLAVE_MEM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Only OKAY/SLVERR/DECERR are ever produced, and their codes already rank by severity.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Whole-burst error: wrong beat size, or a WRAP burst this build cannot serve.
    function automatic logic burst_slverr(input logic [2:0] size, input logic [1:0] burst,
                                          input logic [7:0] len);
        return (size != SIZE_WORD) ||
               ((burst == BURST_WRAP) && !(WRAP_EN && wrap_len_ok(len)));
    endfunction

endpackage

// File: rtl/axi4_slave_mem_addr_gen.sv
// Combinational next-beat byte address for one AXI4 channel (FIXED / INCR / WRAP).
// WRAP is only honoured when AXI4_SLAVE_MEM_WRAP_EN is defined and len is legal; otherwise INCR.
module axi4_slave_mem_addr_gen
    import axi4_slave_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        incr      = addr + ADDR_W'(4);
        // (len+1)*4-1 for the legal wrap lengths: the byte offset within the wrap window
        mask      = (ADDR_W'(len) << 2) | ADDR_W'(3);
        next_addr = incr;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (WRAP_EN && (burst == BURST_WRAP) && wrap_len_ok(len)) begin
            next_addr = (addr & ~mask) | (incr & mask);
        end
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave word memory with independent read/write burst FSMs; r beat 0 follows ar by one cycle.
// Outputs held under backpressure; optional WRAP support via AXI4_SLAVE_MEM_WRAP_EN.
module axi4_slave_mem
    import axi4_slave_mem_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam int IDX_W = $clog2(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    logic [31:0] mem [DEPTH];

    // Keeps the ready outputs low during reset and until the first edge after it.
    logic ready_en_q, ready_en_d;

    r_state_t          r_state_q, r_state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, rnext;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]        rburst_q, rburst_d;
    logic              rerr_q, rerr_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              ar_hs, r_hs, r_done;
    logic [ADDR_W-1:0] rbeat_addr;
    logic              rbeat_err, rbeat_in;

    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, wnext;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs, aw_err, w_hs, w_final, b_hs, w_in, mem_we;

    axi4_slave_mem_addr_gen #(.ADDR_W(ADDR_W)) u_raddr_gen (
        .addr(raddr_q), .len(rlen_q), .burst(rburst_q), .next_addr(rnext)
    );

    axi4_slave_mem_addr_gen #(.ADDR_W(ADDR_W)) u_waddr_gen (
        .addr(waddr_q), .len(wlen_q), .burst(wburst_q), .next_addr(wnext)
    );

    assign ready_en_d = 1'b1;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign r_done  = r_hs && (rcnt_q == rlen_q);
    assign aw_hs   = awvalid && awready;
    assign aw_err  = burst_slverr(awsize, awburst, awlen);
    assign w_hs    = wvalid && wready;
    assign w_final = w_hs && (wcnt_q == wlen_q);
    assign b_hs    = bvalid && bready;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            r_state_q  <= R_IDLE;
        end else begin
            ready_en_q <= ready_en_d;
            r_state_q  <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)  r_state_d = R_BURST;
            R_BURST: if (r_done) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = ready_en_q && (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_BURST);
        rlast   = rvalid && (rcnt_q == rlen_q);
        rid     = rid_q;
        rdata   = rdata_q;
        rresp   = rresp_q;
    end

    // Each beat's data is fetched at the edge that makes it visible, then held until accepted.
    always_comb begin
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        rburst_d   = rburst_q;
        rerr_d     = rerr_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rbeat_addr = rnext;
        rbeat_err  = rerr_q;
        if (ar_hs) begin
            rbeat_addr = araddr;
            rbeat_err  = burst_slverr(arsize, arburst, arlen);
        end
        rbeat_in = in_range(rbeat_addr);
        if (ar_hs || (r_hs && !r_done)) begin
            raddr_d = rbeat_addr;
            rerr_d  = rbeat_err;
            rdata_d = (rbeat_in && !rbeat_err) ? mem[rbeat_addr[IDX_W+1:2]] : 32'h0;
            rresp_d = worst_resp(rbeat_in ? RESP_OKAY : RESP_DECERR,
                                 rbeat_err ? RESP_SLVERR : RESP_OKAY);
        end
        if (ar_hs) begin
            rlen_d   = arlen;
            rburst_d = arburst;
            rid_d    = arid;
            rcnt_d   = 8'd0;
        end else if (r_hs && !r_done) begin
            rcnt_d   = rcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rburst_q <= '0;
            rerr_q   <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rburst_q <= rburst_d;
            rerr_q   <= rerr_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs)   w_state_d = W_DATA;
            W_DATA:  if (w_final) w_state_d = W_RESP;
            W_RESP:  if (b_hs)    w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = ready_en_q && (w_state_q == W_IDLE);
        wready  = (w_state_q == W_DATA);
        bvalid  = (w_state_q == W_RESP);
        bid     = bid_q;
        bresp   = bvalid ? bresp_q : RESP_OKAY;
    end

    // bresp_q accumulates the worst beat outcome; the beat count, not wlast, ends the burst.
    always_comb begin
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        w_in     = in_range(waddr_q);
        mem_we   = w_hs && w_in && !werr_q;
        if (aw_hs) begin
            waddr_d  = awaddr;
            wlen_d   = awlen;
            wburst_d = awburst;
            bid_d    = awid;
            wcnt_d   = 8'd0;
            werr_d   = aw_err;
            bresp_d  = aw_err ? RESP_SLVERR : RESP_OKAY;
        end else if (w_hs) begin
            waddr_d  = wnext;
            wcnt_d   = wcnt_q + 8'd1;
            bresp_d  = worst_resp(bresp_q, w_in ? RESP_OKAY : RESP_DECERR);
            if (wlast != (wcnt_q == wlen_q)) bresp_d = worst_resp(bresp_d, RESP_SLVERR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
        end else begin
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wburst_q <= wburst_d;
            werr_q   <= werr_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && wstrb[i]) mem[waddr_q[IDX_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: a queue-based memory model predicts every r/b beat.
module tb_axi4_slave_mem;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1024;
`ifdef AXI4_SLAVE_MEM_WRAP_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = 3'd2, arsize = 3'd2;
    logic [1:0]  awburst = INCR, arburst = INCR, bresp, rresp;
    logic [3:0]  wstrb = '0;
    logic awvalid = 0, wvalid = 0, wlast = 0, bready = 1, arvalid = 0, rready = 1;
    logic awready, wready, bvalid, arready, rvalid, rlast;

    axi4_slave_mem #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rbeat_t;
    typedef struct packed {logic [1:0] resp; logic [3:0] id;} bbeat_t;

    rbeat_t exp_r[$], got_r[$];
    bbeat_t exp_b[$], got_b[$];
    logic [31:0] mdl [int];
    logic [31:0] wbuf [16];
    int checks = 0, errors = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    function automatic void timeout(input string what);
        checks++;
        errors++;
        $display("FAIL timeout %s: event did not occur within the cycle bound", what);
    endfunction

    // ---------------- model ----------------
    function automatic bit wrap_ok(input logic [1:0] burst, input logic [7:0] len);
        bit legal;
        legal = (burst == WRAP) && (len == 1 || len == 3 || len == 7 || len == 15);
        return WRAP_ON && legal;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] bytes, base;
        if (burst == FIXED) return a;
        if (wrap_ok(burst, len)) begin
            bytes = (32'(len) + 1) * 4;
            base  = a - (a % bytes);
            return base + ((a - base + 32'(4 * i)) % bytes);
        end
        return a + 32'(4 * i);
    endfunction

    function automatic bit burst_bad(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
        return (size != 3'd2) || (burst == WRAP && !wrap_ok(burst, len));
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return (a / 4) >= DEPTH;
    endfunction

    function automatic void push_read_exp(input logic [3:0] id, input logic [31:0] addr,
                                          input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
        rbeat_t e;
        logic [31:0] a;
        bit bad;
        bad = burst_bad(size, burst, len);
        got_r.delete();
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, burst, i);
            e.id = id;
            e.last = (i == int'(len));
            if (oor(a))   begin e.data = 0; e.resp = DECERR; end
            else if (bad) begin e.data = 0; e.resp = SLVERR; end
            else          begin e.data = mdl[int'(a >> 2)]; e.resp = OKAY; end
            exp_r.push_back(e);
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    timeout("unexpected rvalid with no outstanding read beat");
                end else begin
                    check("rdata", rdata, exp_r[0].data);
                    check("rresp", 32'(rresp), 32'(exp_r[0].resp));
                    check("rlast", 32'(rlast), 32'(exp_r[0].last));
                    check("rid", 32'(rid), 32'(exp_r[0].id));
                    if (rready) begin
                        got_r.push_back({rdata, rresp, rlast, rid});
                        exp_r.delete(0);
                    end
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    timeout("unexpected bvalid with no outstanding write");
                end else begin
                    check("bresp", 32'(bresp), 32'(exp_b[0].resp));
                    check("bid", 32'(bid), 32'(exp_b[0].id));
                    if (bready) begin
                        got_b.push_back({bresp, bid});
                        exp_b.delete(0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wait_ar();
        int n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin n++; @(negedge clk); end
        if (!arready) timeout("ar handshake");
        @(posedge clk); #1 arvalid = 0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int stall);
        int n;
        push_read_exp(id, addr, len, burst, size);
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size;
        arvalid = 1; rready = (stall == 0);
        wait_ar();
        @(negedge clk);
        check("rvalid one cycle after ar", 32'(rvalid), 1);
        check("arready low during burst", 32'(arready), 0);
        if (stall > 0) begin
            repeat (stall - 1) @(negedge clk);
            check("rvalid held while stalled", 32'(rvalid), 1);
            check("arready low while stalled", 32'(arready), 0);
            @(posedge clk); #1 rready = 1;
        end
        n = 0;
        while (exp_r.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (exp_r.size() != 0) begin timeout("read burst completion"); exp_r.delete(); end
        @(negedge clk);
        check("arready one cycle after last r", 32'(arready), 1);
        check("rvalid low after last r", 32'(rvalid), 0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                            input bit bad_last);
        bbeat_t e;
        logic [31:0] a, w;
        bit bad, any_oor;
        int n;
        bad = burst_bad(size, burst, len);
        any_oor = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, burst, i);
            if (oor(a)) any_oor = 1;
            else if (!bad) begin
                w = mdl.exists(int'(a >> 2)) ? mdl[int'(a >> 2)] : 32'h0;
                for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wbuf[i][8*b +: 8];
                mdl[int'(a >> 2)] = w;
            end
        end
        e.id = id;
        e.resp = any_oor ? DECERR : ((bad || bad_last) ? SLVERR : OKAY);
        exp_b.push_back(e);
        got_b.delete();
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 50) begin n++; @(negedge clk); end
        if (!awready) timeout("aw handshake");
        @(posedge clk); #1 awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len)) && !bad_last; wvalid = 1;
            n = 0;
            @(negedge clk);
            while (!wready && n < 50) begin n++; @(negedge clk); end
            if (!wready) timeout("w handshake");
            @(posedge clk); #1;
        end
        wvalid = 0; wlast = 0;
        @(negedge clk);
        check("bvalid one cycle after last w", 32'(bvalid), 1);
        n = 0;
        while (exp_b.size() != 0 && n < 50) begin @(posedge clk); n++; end
        if (exp_b.size() != 0) begin timeout("write response"); exp_b.delete(); end
        @(negedge clk);
        check("awready one cycle after b", 32'(awready), 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset arready", 32'(arready), 0);
        check("reset awready", 32'(awready), 0);
        check("reset wready", 32'(wready), 0);
        check("reset rvalid/bvalid/rlast", {29'b0, rvalid, bvalid, rlast}, 0);
        check("reset rdata", rdata, 0);
        check("reset rresp/bresp/rid/bid", {20'b0, rresp, bresp, rid, bid}, 0);
        rst = 0;
        #1 check("arready before first edge", 32'(arready), 0);
        @(negedge clk);
        check("arready after first edge", 32'(arready), 1);
        check("awready after first edge", 32'(awready), 1);

        // INCR write then read back
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(4'h1, 32'h10, 8'd3, INCR, 3'd2, 4'hF, 0);
        check("t1 bresp literal", 32'(got_b[0].resp), 0);
        do_read(4'h2, 32'h10, 8'd3, INCR, 3'd2, 0);
        check("t1 beat count", got_r.size(), 4);
        for (int i = 0; i < 4; i++) check("t1 rdata literal", got_r[i].data, 32'hA0 + 32'(i));
        check("t1 rlast on beat 3", 32'(got_r[3].last), 1);

        // partial strobe merge
        wbuf[0] = 32'h12345678;
        do_write(4'h3, 32'h0, 8'd0, INCR, 3'd2, 4'hF, 0);
        wbuf[0] = 32'hFFFFFFFF;
        do_write(4'h3, 32'h0, 8'd0, INCR, 3'd2, 4'b0101, 0);
        do_read(4'h4, 32'h0, 8'd0, INCR, 3'd2, 0);
        check("strobe merge literal", got_r[0].data, 32'h12FF56FF);

        // rready held low for 5 cycles
        do_read(4'h5, 32'h0, 8'd0, INCR, 3'd2, 5);
        check("stalled read literal", got_r[0].data, 32'h12FF56FF);

        // top of memory: second beat is out of range
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hDEAD0002;
        do_write(4'h6, DEPTH * 4 - 4, 8'd1, INCR, 3'd2, 4'hF, 0);
        check("oor write bresp literal", 32'(got_b[0].resp), 32'(DECERR));
        do_read(4'h7, DEPTH * 4 - 4, 8'd1, INCR, 3'd2, 0);
        check("edge beat0 data literal", got_r[0].data, 32'hCAFE0001);
        check("edge beat0 resp literal", 32'(got_r[0].resp), 0);
        check("oor beat1 data literal", got_r[1].data, 0);
        check("oor beat1 resp literal", 32'(got_r[1].resp), 3);

        // WRAP read of 0x0C, len 3
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h100 + 32'(4 * i);
        do_write(4'h8, 32'h0, 8'd3, INCR, 3'd2, 4'hF, 0);
        do_read(4'h9, 32'h0C, 8'd3, WRAP, 3'd2, 0);
`ifdef AXI4_SLAVE_MEM_WRAP_EN
        check("wrap beat0 literal", got_r[0].data, 32'h10C);
        check("wrap beat1 literal", got_r[1].data, 32'h100);
        check("wrap beat3 literal", got_r[3].data, 32'h108);
        check("wrap resp literal", 32'(got_r[2].resp), 0);
`else
        check("wrap disabled data literal", got_r[1].data, 0);
        check("wrap disabled resp literal", 32'(got_r[0].resp), 2);
        check("wrap disabled resp3 literal", 32'(got_r[3].resp), 2);
`endif

        // FIXED burst: all beats hit one word
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
        do_write(4'hA, 32'h20, 8'd2, FIXED, 3'd2, 4'hF, 0);
        do_read(4'hB, 32'h20, 8'd1, FIXED, 3'd2, 0);
        check("fixed read literal", got_r[1].data, 32'h3);

        // wrong size and missing wlast
        do_read(4'hC, 32'h10, 8'd1, INCR, 3'd1, 0);
        check("bad size resp literal", 32'(got_r[0].resp), 2);
        check("bad size data literal", got_r[1].data, 0);
        wbuf[0] = 32'h55; wbuf[1] = 32'h66;
        do_write(4'hD, 32'h40, 8'd1, INCR, 3'd2, 4'hF, 1);
        check("missing wlast bresp literal", 32'(got_b[0].resp), 2);
        do_read(4'hE, 32'h40, 8'd1, INCR, 3'd2, 0);
        check("missing wlast data literal", got_r[1].data, 32'h66);

        // reset during an 8-beat read, on beat 3
        push_read_exp(4'hF, 32'h0, 8'd7, INCR, 3'd2);
        @(posedge clk); #1;
        arid = 4'hF; araddr = 32'h0; arlen = 8'd7; arburst = INCR; arsize = 3'd2;
        arvalid = 1; rready = 1;
        wait_ar();
        n = 0;
        while (got_r.size() < 3 && n < 50) begin @(posedge clk); n++; end
        if (got_r.size() < 3) timeout("beats before reset");
        #2 rst = 1;
        #1;
        check("rvalid drops on reset", 32'(rvalid), 0);
        check("rlast drops on reset", 32'(rlast), 0);
        check("arready low in reset", 32'(arready), 0);
        exp_r.delete();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("arready low before first edge", 32'(arready), 0);
        @(negedge clk);
        check("arready after reset release", 32'(arready), 1);
        do_read(4'h2, 32'h10, 8'd3, INCR, 3'd2, 0);
        check("post-reset read literal", got_r[2].data, 32'hA2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
